// File: rtl/project_types.sv
// Shared types and helpers for the MEM-stage load/store unit.
package project_types;

    // Memory operation encoding carried on req_op.
    typedef enum logic [3:0] {
        OpLb,
        OpLbu,
        OpLh,
        OpLhu,
        OpLw,
        OpLwu,
        OpLd,
        OpSb,
        OpSh,
        OpSw,
        OpSd
    } mem_op_t;

    // Fault causes reported on exc_code.
    typedef enum logic [1:0] {
        ExcAdel,
        ExcAdes,
        ExcBuserr,
        ExcTimeout
    } exc_code_t;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } lsu_state_t;

    function automatic logic is_load(mem_op_t op);
        case (op)
            OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLwu, OpLd: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed(mem_op_t op);
        case (op)
            OpLb, OpLh, OpLw, OpLd: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Access size in bytes; 0 marks an undefined encoding.
    function automatic logic [3:0] access_bytes(mem_op_t op);
        case (op)
            OpLb, OpLbu, OpSb: return 4'd1;
            OpLh, OpLhu, OpSh: return 4'd2;
            OpLw, OpLwu, OpSw: return 4'd4;
            OpLd, OpSd:        return 4'd8;
            default:           return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: lane enables, alignment/legality check,
// store data replication and load extraction with sign/zero extension.
module mem_lane_align
    import project_types::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [3:0]          op_i,
    input  logic [2:0]          addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [DATA_W/8-1:0] sel_o,
    output logic                fault_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned SelW  = DATA_W / 8;
    localparam int unsigned LaneW = $clog2(SelW);

    mem_op_t           op;
    logic [3:0]        bytes;
    logic [LaneW-1:0]  lane;
    logic [DATA_W-1:0] shifted;

    assign op      = mem_op_t'(op_i);
    assign bytes   = access_bytes(op);
    assign lane    = addr_i[LaneW-1:0];
    // Move the addressed lane down to bit 0 before extension.
    assign shifted = rdata_i >> {lane, 3'b000};

    // Lane enables and misalignment / unsupported-op detection.
    always_comb begin
        sel_o   = '0;
        fault_o = 1'b0;
        case (bytes)
            4'd1: sel_o = SelW'(1) << lane;
            4'd2: begin
                sel_o   = SelW'(2'b11) << lane;
                fault_o = addr_i[0];
            end
            4'd4: begin
                sel_o   = SelW'(4'hF) << lane;
                fault_o = |addr_i[1:0];
            end
            4'd8: begin
                sel_o   = '1;
                fault_o = |addr_i[2:0];
            end
            default: fault_o = 1'b1;
        endcase
        // A 32-bit datapath has no dword ops and no distinct LWU.
        if (DATA_W == 32 && (op == OpLd || op == OpSd || op == OpLwu)) begin
            fault_o = 1'b1;
        end
    end

    // Replicate the low store bytes across every lane.
    always_comb begin
        case (bytes)
            4'd1:    wdata_o = {SelW{wdata_i[7:0]}};
            4'd2:    wdata_o = {(SelW / 2){wdata_i[15:0]}};
            4'd4:    wdata_o = {(SelW / 4){wdata_i[31:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

    // Extract the selected lane and extend to full width.
    always_comb begin
        rdata_o = '0;
        case (bytes)
            4'd1: begin
                if (is_signed(op)) rdata_o = DATA_W'($signed(shifted[7:0]));
                else               rdata_o = DATA_W'(shifted[7:0]);
            end
            4'd2: begin
                if (is_signed(op)) rdata_o = DATA_W'($signed(shifted[15:0]));
                else               rdata_o = DATA_W'(shifted[15:0]);
            end
            4'd4: begin
                if (is_signed(op)) rdata_o = DATA_W'($signed(shifted[31:0]));
                else               rdata_o = DATA_W'(shifted[31:0]);
            end
            4'd8:    rdata_o = shifted;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Multi-cycle MEM-stage load/store unit with a req/ack data bus.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_lsu
    import project_types::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [4:0]          req_rd,
    output logic                stall_o,
    output logic                resp_valid,
    output logic                resp_we,
    output logic [4:0]          resp_rd,
    output logic [DATA_W-1:0]   resp_data,
    output logic                exc_valid,
    output logic [1:0]          exc_code,
    output logic [ADDR_W-1:0]   exc_addr,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_sel,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic                bus_err,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned LaneW = $clog2(SEL_W);

    lsu_state_t        st_q, st_d;
    mem_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        rd_q, rd_d;

    logic              req_ready_q, req_ready_d;
    logic              stall_q, stall_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_we_q, resp_we_d;
    logic [4:0]        resp_rd_q, resp_rd_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              exc_valid_q, exc_valid_d;
    exc_code_t         exc_code_q, exc_code_d;
    logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned ToRawW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ToW    = (ToRawW < 8) ? 8 : ((ToRawW > 16) ? 16 : ToRawW);
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    mem_op_t           req_op_e;
    logic              idle;
    logic [3:0]        al_op;
    logic [2:0]        al_addr;
    logic [SEL_W-1:0]  al_sel;
    logic              al_fault;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;

    assign req_op_e = mem_op_t'(req_op);
    assign idle     = (st_q == StIdle);
    // In IDLE the lane logic decodes the incoming op; afterwards the latched one.
    assign al_op    = idle ? req_op : op_q;
    assign al_addr  = idle ? req_addr[2:0] : addr_q[2:0];

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .op_i    (al_op),
        .addr_i  (al_addr),
        .wdata_i (req_wdata),
        .rdata_i (bus_rdata),
        .sel_o   (al_sel),
        .fault_o (al_fault),
        .wdata_o (al_wdata),
        .rdata_o (al_rdata)
    );

    // Next-state and registered-output computation.
    always_comb begin
        st_d         = st_q;
        op_d         = op_q;
        addr_d       = addr_q;
        rd_d         = rd_q;
        resp_valid_d = 1'b0;
        resp_we_d    = 1'b0;
        resp_rd_d    = resp_rd_q;
        resp_data_d  = '0;
        exc_valid_d  = 1'b0;
        exc_code_d   = exc_code_q;
        exc_addr_d   = exc_addr_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_sel_d    = bus_sel_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
`ifdef MEM_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif

        unique case (st_q)
            StIdle: begin
                if (req_valid) begin
                    op_d   = req_op_e;
                    addr_d = req_addr;
                    rd_d   = req_rd;
                    if (al_fault) begin
                        exc_valid_d = 1'b1;
                        exc_code_d  = is_load(req_op_e) ? ExcAdel : ExcAdes;
                        exc_addr_d  = req_addr;
                    end else begin
                        st_d        = StBus;
                        bus_req_d   = 1'b1;
                        bus_we_d    = ~is_load(req_op_e);
                        bus_sel_d   = al_sel;
                        bus_addr_d  = {req_addr[ADDR_W-1:LaneW], {LaneW{1'b0}}};
                        bus_wdata_d = al_wdata;
`ifdef MEM_TIMEOUT_EN
                        to_cnt_d    = '0;
`endif
                    end
                end
            end
            StBus: begin
                if (bus_err) begin
                    st_d        = StIdle;
                    bus_req_d   = 1'b0;
                    exc_valid_d = 1'b1;
                    exc_code_d  = ExcBuserr;
                    exc_addr_d  = addr_q;
                end else if (bus_ack) begin
                    st_d         = StResp;
                    bus_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_we_d    = is_load(op_q);
                    resp_rd_d    = rd_q;
                    resp_data_d  = is_load(op_q) ? al_rdata : '0;
`ifdef MEM_TIMEOUT_EN
                end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                    st_d        = StIdle;
                    bus_req_d   = 1'b0;
                    exc_valid_d = 1'b1;
                    exc_code_d  = ExcTimeout;
                    exc_addr_d  = addr_q;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            StResp: st_d = StIdle;
            default: st_d = StIdle;
        endcase

        req_ready_d = (st_d == StIdle);
        // Stall covers the whole op, including the resp/exc cycle itself.
        stall_d     = (st_d != StIdle) || exc_valid_d;
    end

    // State, latched request and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= StIdle;
            op_q         <= OpLb;
            addr_q       <= '0;
            rd_q         <= '0;
            req_ready_q  <= 1'b1;
            stall_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_rd_q    <= '0;
            resp_data_q  <= '0;
            exc_valid_q  <= 1'b0;
            exc_code_q   <= ExcAdel;
            exc_addr_q   <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            st_q         <= st_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            req_ready_q  <= req_ready_d;
            stall_q      <= stall_d;
            resp_valid_q <= resp_valid_d;
            resp_we_q    <= resp_we_d;
            resp_rd_q    <= resp_rd_d;
            resp_data_q  <= resp_data_d;
            exc_valid_q  <= exc_valid_d;
            exc_code_q   <= exc_code_d;
            exc_addr_q   <= exc_addr_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
`ifdef MEM_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign stall_o    = stall_q;
    assign resp_valid = resp_valid_q;
    assign resp_we    = resp_we_q;
    assign resp_rd    = resp_rd_q;
    assign resp_data  = resp_data_q;
    assign exc_valid  = exc_valid_q;
    assign exc_code   = exc_code_q;
    assign exc_addr   = exc_addr_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_sel    = bus_sel_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus randomized ops
// against a byte-arithmetic reference model.
module tb_mem_lsu;
    import project_types::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [4:0]    req_rd;
    logic          stall_o;
    logic          resp_valid;
    logic          resp_we;
    logic [4:0]    resp_rd;
    logic [DW-1:0] resp_data;
    logic          exc_valid;
    logic [1:0]    exc_code;
    logic [AW-1:0] exc_addr;
    logic          bus_req;
    logic          bus_we;
    logic [SW-1:0] bus_sel;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic          bus_err;
    logic [DW-1:0] bus_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_lsu #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .stall_o    (stall_o),
        .resp_valid (resp_valid),
        .resp_we    (resp_we),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code),
        .exc_addr   (exc_addr),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_sel    (bus_sel),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_err    (bus_err),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_size(input int op);
        case (op)
            0, 1, 7: return 1;
            2, 3, 8: return 2;
            4, 5, 9: return 4;
            6, 10:   return 8;
            default: return 0;
        endcase
    endfunction

    // Reference: what the bus and writeback should show for one op.
    function automatic void model(input int op, input logic [31:0] addr, input logic [63:0] wd,
                                  input logic [63:0] rd, output bit fault,
                                  output logic [63:0] esel, output logic [63:0] ewd,
                                  output logic [63:0] erd);
        int n;
        int lane;
        logic [63:0] mask;
        logic [63:0] dmask;
        logic [63:0] v;
        n     = op_size(op);
        lane  = int'(addr % SW);
        dmask = (DW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        fault = (n == 0) || ((addr % n) != 0);
        if (DW == 32 && (op == 6 || op == 10 || op == 5)) fault = 1'b1;
        if (n == 0) n = 1;
        mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 1);
        esel = ((64'd1 << n) - 1) << lane;
        esel = esel & ((64'd1 << SW) - 1);
        ewd  = 0;
        for (int i = 0; i < int'(SW) / n; i++) ewd = ewd | ((wd & mask) << (8 * n * i));
        erd = 0;
        if (op <= 6) begin
            v = (rd >> (8 * lane)) & mask;
            if ((op == 0 || op == 2 || op == 4 || op == 6) && v[8 * n - 1]) v = v | ~mask;
            erd = v & dmask;
        end
    endfunction

    // Offer one op, play the bus side, and check everything along the way.
    task automatic run_op(input int op, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [4:0] rd, input logic [63:0] rdat, input int waits,
                          input bit err, input bit both);
        bit fault;
        bit ld;
        logic [63:0] esel, ewd, erd;
        model(op, addr, wd, rdat, fault, esel, ewd, erd);
        ld = (op <= 6);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_op    = 4'(op);
        req_addr  = addr;
        req_wdata = DW'(wd);
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
        req_op    = 4'($urandom_range(0, 10));
        req_addr  = $urandom;
        req_wdata = DW'($urandom);
        if (fault) begin
            check("adr_exc_valid", exc_valid, 1);
            check("adr_exc_code", exc_code, ld ? ExcAdel : ExcAdes);
            check("adr_exc_addr", exc_addr, addr);
            check("adr_no_bus", bus_req, 0);
            check("adr_stall", stall_o, 1);
            tick();
            check("adr_exc_pulse", exc_valid, 0);
            check("adr_stall_end", stall_o, 0);
            return;
        end
        check("bus_req", bus_req, 1);
        check("bus_we", bus_we, !ld);
        check("bus_sel", bus_sel, esel);
        check("bus_addr", bus_addr, addr & ~(AW'(SW - 1)));
        check("stall_busy", stall_o, 1);
        check("ready_busy", req_ready, 0);
        if (!ld) check("bus_wdata", bus_wdata, ewd);
        for (int i = 0; i < waits; i++) begin
            tick();
            check("bus_hold", bus_req, 1);
            check("no_early_resp", resp_valid, 0);
        end
        bus_ack   = !err || both;
        bus_err   = err;
        bus_rdata = DW'(rdat);
        tick();
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = DW'($urandom);
        check("bus_drop", bus_req, 0);
        check("stall_last", stall_o, 1);
        if (err) begin
            check("berr_exc_valid", exc_valid, 1);
            check("berr_exc_code", exc_code, ExcBuserr);
            check("berr_exc_addr", exc_addr, addr);
            check("berr_no_resp", resp_valid, 0);
        end else begin
            check("resp_valid", resp_valid, 1);
            check("resp_we", resp_we, ld);
            check("resp_data", resp_data, erd);
            check("resp_no_exc", exc_valid, 0);
            if (ld) check("resp_rd", resp_rd, rd);
            // Stray ack outside BUS must be ignored.
            bus_ack = 1'($urandom_range(0, 1));
        end
        tick();
        bus_ack = 1'b0;
        check("pulse_end_resp", resp_valid, 0);
        check("pulse_end_exc", exc_valid, 0);
        check("stall_end", stall_o, 0);
    endtask

    initial begin
        int op;
        logic [31:0] a;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_rd    = '0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = '0;
        repeat (3) tick();
        check("rst_ready", req_ready, 1);
        check("rst_stall", stall_o, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_resp", resp_valid, 0);
        check("rst_exc", exc_valid, 0);
        check("rst_sel", bus_sel, 0);
        rst = 1'b0;
        tick();

        run_op(0, 32'h1003, 64'h0, 5'd5, 64'h8000_0000, 0, 0, 0);
        run_op(3, 32'h2002, 64'h0, 5'd6, 64'hBEEF_1234, 3, 0, 0);
        run_op(7, 32'h0001, 64'hA5, 5'd0, 64'h0, 0, 0, 0);
        run_op(4, 32'h0006, 64'h0, 5'd7, 64'h0, 0, 0, 0);
        run_op(9, 32'h0010, 64'h1234_5678, 5'd0, 64'h0, 1, 1, 1);

        // Reset in the middle of a bus transaction.
        req_valid = 1'b1;
        req_op    = 4'(OpLw);
        req_addr  = 32'h100;
        tick();
        req_valid = 1'b0;
        check("rstbus_req", bus_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstbus_drop", bus_req, 0);
        check("rstbus_ready", req_ready, 1);
        bus_ack = 1'b1;
        tick();
        tick();
        bus_ack = 1'b0;
        check("rstbus_no_resp", resp_valid, 0);
        check("rstbus_no_exc", exc_valid, 0);

`ifdef MEM_TIMEOUT_EN
        req_valid = 1'b1;
        req_op    = 4'(OpLw);
        req_addr  = 32'h40;
        tick();
        req_valid = 1'b0;
        check("to_req1", bus_req, 1);
        repeat (3) begin
            tick();
            check("to_req_hold", bus_req, 1);
        end
        tick();
        check("to_drop", bus_req, 0);
        check("to_exc_valid", exc_valid, 1);
        check("to_exc_code", exc_code, ExcTimeout);
        check("to_exc_addr", exc_addr, 32'h40);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("to_late_ack", resp_valid, 0);
        check("to_idle", req_ready, 1);
`endif

        for (int k = 0; k < 150; k++) begin
            op = $urandom_range(0, 10);
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~32'(op_size(op) - 1);
            run_op(op, a, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                   {$urandom, $urandom}, $urandom_range(0, 3),
                   $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
